// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types for the divider datapath: operand width and the
//                operand-pair request carried from the issue buffer into the
//                divider wrapper.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH = 32;

    // One operand pair plus its precomputed divide-by-zero marker
    typedef struct packed {
        logic [DIV_WIDTH-1:0] dividend;
        logic [DIV_WIDTH-1:0] divisor;
        logic                 div_zero;
    } div_req_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_operand_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : div_operand_fifo
//  Description : Operand issue buffer in front of the combinational divider.
//                Queues dividend/divisor pairs behind a valid/ready handshake
//                and presents the oldest pair, with a divide-by-zero flag
//                computed at enqueue, on a second valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_operand_fifo
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_dividend,
    output logic [WIDTH-1:0] out_divisor,
    output logic             out_div_zero,
    output logic [CW-1:0]    count
);

    localparam int        PW         = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

    // Storage is deliberately not reset; occupancy is tracked by r_count
    div_req_t        r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_push;
    logic            w_pop;
    div_req_t        w_head;
    div_req_t        w_new;

    // Ready depends on state only, so a pop while full never admits a push
    assign w_in_ready  = (r_count < c_FULL) && rst_n;
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid && w_in_ready;
    assign w_pop       = w_out_valid && out_ready;

    assign w_new.dividend = in_dividend;
    assign w_new.divisor  = in_divisor;
    assign w_new.div_zero = (in_divisor == '0);

    assign w_head = r_mem[r_rd_ptr];

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_dividend = w_out_valid ? w_head.dividend : '0;
    assign out_divisor  = w_out_valid ? w_head.divisor  : '0;
    assign out_div_zero = w_out_valid ? w_head.div_zero : 1'b0;
    assign count        = r_count;

    // Write accepted pairs into storage at the write pointer
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    // Pointer and occupancy update; reset beats flush beats push/pop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : div_operand_fifo
`default_nettype wire

// File: tb/tb_div_operand_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_operand_fifo
//  Description : Directed self-checking bench for div_operand_fifo.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_operand_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dividend;
    logic [WIDTH-1:0] in_divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_dividend;
    logic [WIDTH-1:0] out_divisor;
    logic             out_div_zero;
    logic [CW-1:0]    count;

    int n_cmp = 0;
    int n_err = 0;

    div_operand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dividend  (in_dividend),
        .in_divisor   (in_divisor),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_dividend (out_dividend),
        .out_divisor  (out_divisor),
        .out_div_zero (out_div_zero),
        .count        (count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] v);
        in_valid    = 1'b1;
        in_dividend = d;
        in_divisor  = v;
        tick();
        in_valid    = 1'b0;
    endtask

    initial begin : main
        logic [15:0] pat;
        int          sent;
        int          rcv;
        int          cyc;
        logic        do_push;
        logic        do_pop;

        pat         = 16'b1011_0010_1110_0101;
        rst_n       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        in_dividend = '0;
        in_divisor  = '0;
        out_ready   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check_val("rst_in_ready",  in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_count",     count, 0);
        check_val("rst_out_div",   out_dividend, 0);
        check_val("rst_out_dz",    out_div_zero, 0);
        rst_n = 1'b1;
        #1;
        check_val("rel_in_ready", in_ready, 1);

        // ---------------- single push, hold ----------------
        push(32'h0000_000F, 32'h2);
        check_val("t1_valid", out_valid, 1);
        check_val("t1_dvd",   out_dividend, 32'hF);
        check_val("t1_dvs",   out_divisor, 32'h2);
        check_val("t1_dz",    out_div_zero, 0);
        check_val("t1_count", count, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t1_hold_dvd",   out_dividend, 32'hF);
            check_val("t1_hold_count", count, 1);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("t1_pop_count", count, 0);

        // ---------------- zero-divisor flag ----------------
        push(32'h10, 32'h2);
        push(32'h10, 32'h0);
        check_val("t2_count", count, 2);
        check_val("t2_dz_a",  out_div_zero, 0);
        check_val("t2_dvs_a", out_divisor, 32'h2);
        out_ready = 1'b1;
        tick();
        check_val("t2_dz_b",  out_div_zero, 1);
        check_val("t2_dvs_b", out_divisor, 32'h0);
        check_val("t2_dvd_b", out_dividend, 32'h10);
        tick();
        out_ready = 1'b0;
        check_val("t2_count_end", count, 0);
        check_val("t2_valid_end", out_valid, 0);
        check_val("t2_dvd_end",   out_dividend, 0);

        // ---------------- full: no push while popping ----------------
        for (int k = 0; k < 4; k++) push(32'h100 + k, 32'h7);
        check_val("t3_in_ready", in_ready, 0);
        check_val("t3_count",    count, 4);
        in_valid    = 1'b1;
        in_dividend = 32'hBAD;
        in_divisor  = 32'h1;
        out_ready   = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("t3_count_after", count, 3);
        check_val("t3_head",        out_dividend, 32'h101);
        out_ready = 1'b1;
        tick();
        check_val("t3_head2", out_dividend, 32'h102);
        tick();
        check_val("t3_head3", out_dividend, 32'h103);
        tick();
        out_ready = 1'b0;
        check_val("t3_drained", count, 0);

        // ---------------- streaming with pattern backpressure ----------------
        sent = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 12 && cyc < 200) begin
            in_valid    = (sent < 12);
            in_dividend = sent;
            in_divisor  = sent + 1;
            out_ready   = pat[cyc % 16];
            do_push     = in_valid && in_ready;
            do_pop      = out_valid && out_ready;
            if (do_pop) begin
                check_val("t4_dvd", out_dividend, rcv);
                check_val("t4_dvs", out_divisor,  rcv + 1);
                check_val("t4_dz",  out_div_zero, 0);
                rcv++;
            end
            if (do_push) sent++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("t4_received", rcv, 12);
        check_val("t4_count_end", count, 0);

        // ---------------- flush overrides push ----------------
        push(32'h21, 32'h3);
        push(32'h22, 32'h3);
        push(32'h23, 32'h3);
        check_val("t5_count_pre", count, 3);
        flush       = 1'b1;
        in_valid    = 1'b1;
        in_dividend = 32'hDEAD;
        in_divisor  = 32'h1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_val("t5_count",     count, 0);
        check_val("t5_valid",     out_valid, 0);
        check_val("t5_dvd",       out_dividend, 0);
        push(32'h55, 32'h5);
        check_val("t5_after_cnt", count, 1);
        check_val("t5_after_dvd", out_dividend, 32'h55);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // ---------------- reset mid-operation ----------------
        push(32'h31, 32'h0);
        push(32'h32, 32'h4);
        check_val("t6_count_pre", count, 2);
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_dividend = 32'hBEEF;
        in_divisor  = 32'h9;
        out_ready   = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check_val("t6_valid",    out_valid, 0);
        check_val("t6_count",    count, 0);
        check_val("t6_in_ready", in_ready, 0);
        rst_n = 1'b1;
        #1;
        check_val("t6_rel_ready", in_ready, 1);
        push(32'h77, 32'h0);
        check_val("t6_new_dvd", out_dividend, 32'h77);
        check_val("t6_new_dz",  out_div_zero, 1);
        check_val("t6_new_cnt", count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_div_operand_fifo
`default_nettype wire
